// File: rtl/axis_pkg.sv
// Shared constants and state encoding for the AXI4-Stream register slice.
package axis_pkg;

    localparam int unsigned AXIS_MODE_BYPASS = 0;
    localparam int unsigned AXIS_MODE_FWD    = 1;
    localparam int unsigned AXIS_MODE_FULL   = 2;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } skid_state_t;

endpackage

// File: rtl/axis_skid_stage.sv
// Two-entry skid buffer: every output (valid, beat, ready, occupancy) comes straight from a flop.
module axis_skid_stage
    import axis_pkg::*;
#(
    parameter int unsigned W = 5
) (
    input  logic         clk_i,
    input  logic         arstn_i,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [W-1:0] s_beat,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [W-1:0] m_beat,
    output logic [1:0]   occ
);

    skid_state_t  state, state_nxt;
    logic [W-1:0] main_q, skid_q;
    logic         valid_q, ready_q;
    logic [1:0]   occ_q;
    logic         in_hs, out_hs;

    assign in_hs  = s_valid & ready_q;
    assign out_hs = valid_q & m_ready;

    always_comb begin
        state_nxt = state;
        unique case (state)
            EMPTY: if (in_hs) state_nxt = ONE;
            ONE: begin
                if (in_hs && !out_hs)      state_nxt = TWO;
                else if (out_hs && !in_hs) state_nxt = EMPTY;
            end
            TWO:     if (out_hs) state_nxt = ONE;
            default: state_nxt = EMPTY;
        endcase
    end

    // Status flops are loaded from the next state so they line up with the data registers.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state   <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b0;
            occ_q   <= '0;
        end else begin
            state   <= state_nxt;
            valid_q <= (state_nxt != EMPTY);
            ready_q <= (state_nxt != TWO);
            occ_q   <= 2'(state_nxt);
            unique case (state)
                EMPTY: if (in_hs) main_q <= s_beat;
                ONE: begin
                    if (in_hs && out_hs) main_q <= s_beat;
                    else if (in_hs)      skid_q <= s_beat;
                end
                TWO:     if (out_hs) main_q <= skid_q;
                default: ;
            endcase
        end
    end

    assign s_ready = ready_q;
    assign m_valid = valid_q;
    assign m_beat  = main_q;
    assign occ     = occ_q;

endmodule

// File: rtl/axis_reg_slice.sv
// AXI4-Stream register slice with bypass, forward-registered and full skid modes.
module axis_reg_slice
    import axis_pkg::*;
#(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned MODE   = 2
) (
    input  logic              clk_i,
    input  logic              arstn_i,
    input  logic              tvalid_i,
    output logic              tready_o,
    input  logic [DATA_W-1:0] tdata_i,
    input  logic              tlast_i,
    output logic              tvalid_o,
    input  logic              tready_i,
    output logic [DATA_W-1:0] tdata_o,
    output logic              tlast_o,
    output logic [1:0]        occ_o
);

    localparam int unsigned BEAT_W = DATA_W + 1;

    generate
        if (MODE == AXIS_MODE_BYPASS) begin : g_bypass
            assign tready_o = tready_i;
            assign tvalid_o = tvalid_i;
            assign tdata_o  = tdata_i;
            assign tlast_o  = tlast_i;
            assign occ_o    = '0;
        end else if (MODE == AXIS_MODE_FWD) begin : g_fwd
            logic              valid_q;
            logic [BEAT_W-1:0] main_q;
            logic              ready;

            assign ready = ~valid_q | tready_i;

            always_ff @(posedge clk_i or negedge arstn_i) begin
                if (!arstn_i) begin
                    valid_q <= 1'b0;
                    main_q  <= '0;
                end else if (tvalid_i && ready) begin
                    main_q  <= {tlast_i, tdata_i};
                    valid_q <= 1'b1;
                end else if (tready_i) begin
                    valid_q <= 1'b0;
                end
            end

            assign tready_o = ready;
            assign tvalid_o = valid_q;
            assign {tlast_o, tdata_o} = main_q;
            assign occ_o    = {1'b0, valid_q};
        end else if (MODE == AXIS_MODE_FULL) begin : g_full
            logic [BEAT_W-1:0] m_beat;

            axis_skid_stage #(.W(BEAT_W)) u_skid (
                .clk_i   (clk_i),
                .arstn_i (arstn_i),
                .s_valid (tvalid_i),
                .s_ready (tready_o),
                .s_beat  ({tlast_i, tdata_i}),
                .m_valid (tvalid_o),
                .m_ready (tready_i),
                .m_beat  (m_beat),
                .occ     (occ_o)
            );

            assign {tlast_o, tdata_o} = m_beat;
        end else begin : g_bad_mode
            $error("axis_reg_slice: unsupported MODE %0d", MODE);
        end
    endgenerate

endmodule
